// File: rtl/spi_tx_scheduler_pkg.sv
// Shared definitions for the SPI transmit scheduler: state encoding, widths,
// the default identification word, tx_valid byte-lane constants and the
// pending-flag update helper.
package spi_tx_scheduler_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned VALID_W = 4;
    localparam int unsigned META_W  = 8;
    localparam int unsigned CNT_W   = 16;

    // "SLA1", sent least-significant byte first
    localparam logic [DATA_W-1:0]  ID_WORD_DEFAULT = 32'h31414C53;
    localparam logic [VALID_W-1:0] TX_VALID_WORD   = 4'hF;
    localparam logic [VALID_W-1:0] TX_VALID_BYTE   = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META_RD,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    // A pulse landing on an already-pending flag that is granted keeps it set;
    // a pulse served straight from the input in its own cycle is consumed.
    function automatic logic pend_next(input logic pend, input logic pulse, input logic grant);
        return pend ? (~grant | pulse) : (pulse & ~grant);
    endfunction

endpackage

// File: rtl/spi_busy_watchdog.sv
// Saturating 16-bit watchdog: armed by start, disarmed by hit, flags expire
// in the TIMEOUT-th armed cycle that passes without hit.
module spi_busy_watchdog
    import spi_tx_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic extReset,
    input  logic start,
    input  logic hit,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_running;

    assign expire = r_running && !hit && (r_count >= LIMIT);

    // Count armed cycles, saturating at all-ones
    always_ff @(posedge clock) begin
        if (extReset) begin
            r_count   <= '0;
            r_running <= 1'b0;
        end else if (start) begin
            r_count   <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (hit || expire) begin
                r_running <= 1'b0;
            end else if (r_count != '1) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Arbitrates ID / dataIn / metadata / sample requests onto a single SPI
// transmitter load interface. Optional metadata streaming is enabled by
// defining SPI_TX_META_EN.
module spi_tx_scheduler
    import spi_tx_scheduler_pkg::*;
#(
    parameter logic [DATA_W-1:0] ID_WORD      = ID_WORD_DEFAULT,
    parameter int unsigned       BUSY_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               extReset,
    input  logic               query_id,
    input  logic               query_dataIn,
    input  logic               query_metadata,
    input  logic [DATA_W-1:0]  dataIn,
    input  logic               samp_req,
    input  logic [DATA_W-1:0]  samp_data,
    input  logic [VALID_W-1:0] samp_valid,
    output logic               samp_ack,
    output logic               meta_rd,
    input  logic [META_W-1:0]  meta_data,
    input  logic               meta_last,
    output logic               tx_send,
    output logic [DATA_W-1:0]  tx_data,
    output logic [VALID_W-1:0] tx_valid,
    input  logic               tx_busy,
    output logic               tx_timeout
);

    state_t             r_state;
    logic               r_pend_id;
    logic               r_pend_din;
    logic [DATA_W-1:0]  r_tx_data;
    logic [VALID_W-1:0] r_tx_valid;
    logic               r_tx_send;
    logic               r_samp_ack;
    logic               r_tx_timeout;

    logic w_idle_ok;
    logic w_req_id;
    logic w_req_din;
    logic w_grant_id;
    logic w_grant_din;
    logic w_grant_samp;
    logic w_wd_start;
    logic w_wd_expire;

`ifdef SPI_TX_META_EN
    logic r_pend_meta;
    logic r_meta_rd;
    logic r_meta_cap;
    logic r_meta_last;
    logic r_in_meta;
    logic w_req_meta;
    logic w_grant_meta;
`else
    logic w_unused_meta;
    assign w_unused_meta = ^{query_metadata, meta_data, meta_last};
`endif

    // Fixed-priority arbiter; a pulse arriving this cycle competes immediately
    assign w_idle_ok   = (r_state == ST_IDLE) && !tx_busy;
    assign w_req_id    = r_pend_id | query_id;
    assign w_req_din   = r_pend_din | query_dataIn;
    assign w_grant_id  = w_idle_ok && w_req_id;
    assign w_grant_din = w_idle_ok && !w_req_id && w_req_din;
`ifdef SPI_TX_META_EN
    assign w_req_meta   = r_pend_meta | query_metadata;
    assign w_grant_meta = w_idle_ok && !w_req_id && !w_req_din && w_req_meta;
    assign w_grant_samp = w_idle_ok && !w_req_id && !w_req_din && !w_req_meta && samp_req;
`else
    assign w_grant_samp = w_idle_ok && !w_req_id && !w_req_din && samp_req;
`endif

    assign w_wd_start = (r_state == ST_LOAD);

    spi_busy_watchdog #(
        .TIMEOUT (BUSY_TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .extReset (extReset),
        .start    (w_wd_start),
        .hit      (tx_busy),
        .expire   (w_wd_expire)
    );

    // Scheduler FSM with registered transmitter and handshake outputs
    always_ff @(posedge clock) begin
        if (extReset) begin
            r_state      <= ST_IDLE;
            r_pend_id    <= 1'b0;
            r_pend_din   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= '0;
            r_tx_send    <= 1'b0;
            r_samp_ack   <= 1'b0;
            r_tx_timeout <= 1'b0;
`ifdef SPI_TX_META_EN
            r_pend_meta  <= 1'b0;
            r_meta_rd    <= 1'b0;
            r_meta_cap   <= 1'b0;
            r_meta_last  <= 1'b0;
            r_in_meta    <= 1'b0;
`endif
        end else begin
            r_pend_id    <= pend_next(r_pend_id, query_id, w_grant_id);
            r_pend_din   <= pend_next(r_pend_din, query_dataIn, w_grant_din);
            r_tx_send    <= 1'b0;
            r_samp_ack   <= 1'b0;
            r_tx_timeout <= 1'b0;
`ifdef SPI_TX_META_EN
            r_pend_meta  <= pend_next(r_pend_meta, query_metadata, w_grant_meta);
            r_meta_rd    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_id) begin
                        r_tx_data  <= ID_WORD;
                        r_tx_valid <= TX_VALID_WORD;
                        r_tx_send  <= 1'b1;
                        r_state    <= ST_LOAD;
                    end else if (w_grant_din) begin
                        r_tx_data  <= dataIn;
                        r_tx_valid <= TX_VALID_WORD;
                        r_tx_send  <= 1'b1;
                        r_state    <= ST_LOAD;
`ifdef SPI_TX_META_EN
                    end else if (w_grant_meta) begin
                        r_meta_rd  <= 1'b1;
                        r_meta_cap <= 1'b0;
                        r_in_meta  <= 1'b1;
                        r_state    <= ST_META_RD;
`endif
                    end else if (w_grant_samp) begin
                        r_tx_data  <= samp_data;
                        r_tx_valid <= samp_valid;
                        r_tx_send  <= 1'b1;
                        r_samp_ack <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_META_RD: begin
`ifdef SPI_TX_META_EN
                    // First cycle issues the pop, second captures the byte
                    if (!r_meta_cap) begin
                        r_meta_cap <= 1'b1;
                    end else begin
                        r_tx_data   <= DATA_W'(meta_data);
                        r_tx_valid  <= TX_VALID_BYTE;
                        r_meta_last <= meta_last;
                        r_tx_send   <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_wd_expire) begin
                        r_tx_timeout <= 1'b1;
                        r_state      <= ST_IDLE;
`ifdef SPI_TX_META_EN
                        r_in_meta    <= 1'b0;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef SPI_TX_META_EN
                        if (r_in_meta && !r_meta_last) begin
                            r_meta_rd  <= 1'b1;
                            r_meta_cap <= 1'b0;
                            r_state    <= ST_META_RD;
                        end else begin
                            r_in_meta <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_send    = r_tx_send;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign samp_ack   = r_samp_ack;
    assign tx_timeout = r_tx_timeout;
`ifdef SPI_TX_META_EN
    assign meta_rd    = r_meta_rd;
`else
    assign meta_rd    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a transmitter busy model and a
// three-byte metadata source.
module tb_spi_tx_scheduler;

    logic        clock = 1'b0;
    logic        extReset = 1'b1;
    logic        query_id = 1'b0;
    logic        query_dataIn = 1'b0;
    logic        query_metadata = 1'b0;
    logic [31:0] dataIn = 32'h0;
    logic        samp_req = 1'b0;
    logic [31:0] samp_data = 32'h0;
    logic [3:0]  samp_valid = 4'h0;
    logic        samp_ack;
    logic        meta_rd;
    logic [7:0]  meta_data = 8'h0;
    logic        meta_last = 1'b0;
    logic        tx_send;
    logic [31:0] tx_data;
    logic [3:0]  tx_valid;
    logic        tx_busy;
    logic        tx_timeout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    spi_tx_scheduler dut (
        .clock          (clock),
        .extReset       (extReset),
        .query_id       (query_id),
        .query_dataIn   (query_dataIn),
        .query_metadata (query_metadata),
        .dataIn         (dataIn),
        .samp_req       (samp_req),
        .samp_data      (samp_data),
        .samp_valid     (samp_valid),
        .samp_ack       (samp_ack),
        .meta_rd        (meta_rd),
        .meta_data      (meta_data),
        .meta_last      (meta_last),
        .tx_send        (tx_send),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_busy        (tx_busy),
        .tx_timeout     (tx_timeout)
    );

    // Transmitter model: busy for busy_len cycles after each tx_send
    logic [7:0] busy_len = 8'd10;
    logic [7:0] busy_left = 8'd0;
    always @(posedge clock) begin
        if (tx_send) busy_left <= busy_len;
        else if (busy_left != 8'd0) busy_left <= busy_left - 8'd1;
    end
    assign tx_busy = (busy_left != 8'd0);

    // Metadata source: byte valid the cycle after each pop
    logic [7:0] m_bytes [3] = '{8'h01, 8'h20, 8'h00};
    logic [1:0] m_idx = 2'd0;
    always @(posedge clock) begin
        if (meta_rd && m_idx < 2'd3) begin
            meta_data <= m_bytes[m_idx];
            meta_last <= (m_idx == 2'd2);
            m_idx     <= m_idx + 2'd1;
        end
    end

    // Output log, sampled mid-cycle
    int          cyc = 0;
    logic [31:0] send_data_q [$];
    logic [3:0]  send_valid_q [$];
    int          send_cyc_q [$];
    int          tmo_cyc_q [$];
    int          ack_cnt = 0;
    int          ack_send_cnt = 0;
    int          mrd_cnt = 0;
    always @(negedge clock) begin
        cyc++;
        if (tx_send) begin
            send_data_q.push_back(tx_data);
            send_valid_q.push_back(tx_valid);
            send_cyc_q.push_back(cyc);
        end
        if (tx_timeout) tmo_cyc_q.push_back(cyc);
        if (samp_ack) ack_cnt++;
        if (samp_ack && tx_send) ack_send_cnt++;
        if (meta_rd) mrd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            if (samp_ack) samp_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        extReset = 1'b1;
        tick(2);
        n_vec++;
        if ({tx_send, samp_ack, meta_rd, tx_timeout} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_pulses: got %b want 0000", {tx_send, samp_ack, meta_rd, tx_timeout});
        end
        n_vec++;
        if (tx_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_tx_data: got %h want 00000000", tx_data);
        end
        n_vec++;
        if (tx_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_tx_valid: got %h want 0", tx_valid);
        end
        extReset = 1'b0;
        tick(2);
    endtask

    task automatic test_id();
        int b = send_data_q.size();
        int t = tmo_cyc_q.size();
        busy_len = 8'd10;
        query_id = 1'b1;
        tick(1);
        query_id = 1'b0;
        tick(30);
        n_vec++;
        if (send_data_q.size() - b != 1) begin
            n_bad++;
            $display("FAIL id_send_count: got %0d want 1", send_data_q.size() - b);
        end
        n_vec++;
        if (send_data_q.size() <= b || send_data_q[b] !== 32'h31414C53) begin
            n_bad++;
            $display("FAIL id_data: got %h want 31414c53", (send_data_q.size() > b) ? send_data_q[b] : 32'h0);
        end
        n_vec++;
        if (send_valid_q.size() <= b || send_valid_q[b] !== 4'hF) begin
            n_bad++;
            $display("FAIL id_valid: got %h want f", (send_valid_q.size() > b) ? send_valid_q[b] : 4'h0);
        end
        n_vec++;
        if (tmo_cyc_q.size() != t) begin
            n_bad++;
            $display("FAIL id_no_timeout: got %0d timeouts want 0", tmo_cyc_q.size() - t);
        end
    endtask

    task automatic test_priority();
        int b  = send_data_q.size();
        int a  = ack_cnt;
        int as = ack_send_cnt;
        busy_len   = 8'd10;
        samp_data  = 32'hA5A50001;
        samp_valid = 4'h3;
        samp_req   = 1'b1;
        query_id   = 1'b1;
        tick(1);
        query_id = 1'b0;
        tick(60);
        n_vec++;
        if (send_data_q.size() - b != 2) begin
            n_bad++;
            $display("FAIL prio_send_count: got %0d want 2", send_data_q.size() - b);
        end
        n_vec++;
        if (send_data_q.size() <= b || send_data_q[b] !== 32'h31414C53) begin
            n_bad++;
            $display("FAIL prio_first_id: got %h want 31414c53", (send_data_q.size() > b) ? send_data_q[b] : 32'h0);
        end
        n_vec++;
        if (send_data_q.size() <= b + 1 || send_data_q[b+1] !== 32'hA5A50001) begin
            n_bad++;
            $display("FAIL prio_second_samp: got %h want a5a50001", (send_data_q.size() > b + 1) ? send_data_q[b+1] : 32'h0);
        end
        n_vec++;
        if (send_valid_q.size() <= b + 1 || send_valid_q[b+1] !== 4'h3) begin
            n_bad++;
            $display("FAIL prio_samp_valid: got %h want 3", (send_valid_q.size() > b + 1) ? send_valid_q[b+1] : 4'h0);
        end
        n_vec++;
        if (ack_cnt - a != 1) begin
            n_bad++;
            $display("FAIL prio_ack_count: got %0d want 1", ack_cnt - a);
        end
        n_vec++;
        if (ack_send_cnt - as != 1) begin
            n_bad++;
            $display("FAIL prio_ack_with_send: got %0d want 1", ack_send_cnt - as);
        end
    endtask

    task automatic test_timeout();
        int b = send_data_q.size();
        int t = tmo_cyc_q.size();
        int k = 0;
        int d;
        busy_len     = 8'd0;
        dataIn       = 32'h12345678;
        query_dataIn = 1'b1;
        tick(1);
        query_dataIn = 1'b0;
        tick(2);
        query_id = 1'b1;
        tick(1);
        query_id = 1'b0;
        while (!tx_timeout && k < 60) begin
            tick(1);
            k++;
        end
        n_vec++;
        if (!tx_timeout) begin
            n_bad++;
            $display("FAIL tmo_seen: got 0 want 1 within 60 cycles");
        end
        busy_len = 8'd4;
        tick(40);
        n_vec++;
        if (tmo_cyc_q.size() - t != 1) begin
            n_bad++;
            $display("FAIL tmo_count: got %0d want 1", tmo_cyc_q.size() - t);
        end
        d = (tmo_cyc_q.size() > t && send_cyc_q.size() > b) ? tmo_cyc_q[t] - send_cyc_q[b] : -1;
        n_vec++;
        if (d != 17) begin
            n_bad++;
            $display("FAIL tmo_latency: got %0d cycles after send want 17", d);
        end
        n_vec++;
        if (send_data_q.size() - b != 2) begin
            n_bad++;
            $display("FAIL tmo_send_count: got %0d want 2", send_data_q.size() - b);
        end
        n_vec++;
        if (send_data_q.size() <= b || send_data_q[b] !== 32'h12345678) begin
            n_bad++;
            $display("FAIL tmo_first_data: got %h want 12345678", (send_data_q.size() > b) ? send_data_q[b] : 32'h0);
        end
        n_vec++;
        if (send_data_q.size() <= b + 1 || send_data_q[b+1] !== 32'h31414C53) begin
            n_bad++;
            $display("FAIL tmo_next_served: got %h want 31414c53", (send_data_q.size() > b + 1) ? send_data_q[b+1] : 32'h0);
        end
    endtask

`ifdef SPI_TX_META_EN
    task automatic test_meta_stream();
        logic [31:0] exp_d [4] = '{32'h01, 32'h20, 32'h00, 32'h31414C53};
        logic [3:0]  exp_v [4] = '{4'h1, 4'h1, 4'h1, 4'hF};
        int b = send_data_q.size();
        int m = mrd_cnt;
        busy_len       = 8'd10;
        query_metadata = 1'b1;
        tick(1);
        query_metadata = 1'b0;
        tick(8);
        query_id = 1'b1;
        tick(1);
        query_id = 1'b0;
        tick(200);
        n_vec++;
        if (send_data_q.size() - b != 4) begin
            n_bad++;
            $display("FAIL meta_send_count: got %0d want 4", send_data_q.size() - b);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (send_data_q.size() <= b + i || send_data_q[b+i] !== exp_d[i] || send_valid_q[b+i] !== exp_v[i]) begin
                n_bad++;
                $display("FAIL meta_send_%0d: got %h/%h want %h/%h", i,
                         (send_data_q.size() > b + i) ? send_data_q[b+i] : 32'h0,
                         (send_valid_q.size() > b + i) ? send_valid_q[b+i] : 4'h0, exp_d[i], exp_v[i]);
            end
        end
        n_vec++;
        if (mrd_cnt - m != 3) begin
            n_bad++;
            $display("FAIL meta_rd_count: got %0d want 3", mrd_cnt - m);
        end
    endtask
`else
    task automatic test_meta_disabled();
        int b = send_data_q.size();
        int m = mrd_cnt;
        query_metadata = 1'b1;
        tick(1);
        query_metadata = 1'b0;
        tick(40);
        n_vec++;
        if (mrd_cnt - m != 0) begin
            n_bad++;
            $display("FAIL nometa_rd_count: got %0d want 0", mrd_cnt - m);
        end
        n_vec++;
        if (send_data_q.size() - b != 0) begin
            n_bad++;
            $display("FAIL nometa_send_count: got %0d want 0", send_data_q.size() - b);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int b = send_data_q.size();
        int t = tmo_cyc_q.size();
        int a = ack_cnt;
        busy_len     = 8'd10;
        dataIn       = 32'hDEADBEEF;
        query_dataIn = 1'b1;
        tick(1);
        query_dataIn = 1'b0;
        query_id     = 1'b1;
        tick(1);
        query_id = 1'b0;
        tick(2);
        extReset = 1'b1;
        tick(1);
        n_vec++;
        if ({tx_send, samp_ack, meta_rd, tx_timeout} !== 4'b0000 || tx_data !== 32'h0 || tx_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %b/%h/%h want 0000/00000000/0",
                     {tx_send, samp_ack, meta_rd, tx_timeout}, tx_data, tx_valid);
        end
        extReset = 1'b0;
        tick(40);
        n_vec++;
        if (send_data_q.size() - b != 1) begin
            n_bad++;
            $display("FAIL midrst_send_count: got %0d want 1", send_data_q.size() - b);
        end
        n_vec++;
        if (send_data_q.size() <= b || send_data_q[b] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL midrst_data: got %h want deadbeef", (send_data_q.size() > b) ? send_data_q[b] : 32'h0);
        end
        n_vec++;
        if (tmo_cyc_q.size() != t || ack_cnt != a) begin
            n_bad++;
            $display("FAIL midrst_no_tmo_ack: got %0d timeouts %0d acks want 0 0", tmo_cyc_q.size() - t, ack_cnt - a);
        end
    endtask

    initial begin
        test_reset();
        test_id();
        test_priority();
        test_timeout();
`ifdef SPI_TX_META_EN
        test_meta_stream();
`else
        test_meta_disabled();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
